a_loader: RTL
=============

// Module: a_loader
// PURPOSE
//  Upstream feeder for the A-operand memory of the systolic matrix unit.
//  - Accepts DIM packed rows of a DIM x DIM signed matrix on a valid/ready stream.
//  - Writes each row into A memory (Ain/Arow/WrEn).
//  - Then asserts the A-memory shift enable (en) for STREAM_CYCLES cycles and pulses done.
// PARAMETERS
//  BITS_AB        8            width of one signed A element
//  DIM            8            matrix dimension; rows per load; elements per row
//  STREAM_CYCLES  2*DIM-1      cycles en is held high after the last row write
// PORTS
//  clk       in   1              clock; all logic on posedge
//  rst       in   1              reset; synchronous, active-high
//  start     in   1              begin a load; sampled only in IDLE
//  in_valid  in   1              packed row valid
//  in_ready  out  1              row accepted when in_valid && in_ready
//  in_data   in   DIM*BITS_AB    packed row; elem i = in_data[i*BITS_AB +: BITS_AB]
//  Ain       out  DIM x BITS_AB  signed row to A memory (unpacked array [DIM-1:0])
//  Arow      out  $clog2(DIM)    row index for the write
//  WrEn      out  1              A-memory write strobe
//  en        out  1              A-memory shift enable
//  busy      out  1              high in every state except IDLE
//  done      out  1              one-cycle pulse at end of STREAM
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=0, WrEn=0, en=0, done=0, busy=0, Arow=0, Ain all 0.
//  - Reset mid-operation aborts immediately: no further WrEn/en, no done pulse.
//  - FSM states: IDLE -> LOAD -> (XPOSE when the transpose macro is defined) -> STREAM -> DONE -> IDLE.
//  - IDLE:
//    - in_ready=0.
//    - start=1 -> LOAD; row counter cleared.
//    - start outside IDLE is ignored.
//  - LOAD:
//    - in_ready=1.
//    - Each handshake at cycle t registers Ain/Arow=row and WrEn=1 at t+1, then row++.
//    - Back-to-back handshakes give WrEn on consecutive cycles.
//    - in_valid gaps hold WrEn=0.
//    - Handshake on row DIM-1:
//      - in_ready drops the next cycle.
//      - FSM enters STREAM the cycle after the last WrEn.
//      - WrEn and en are never high in the same cycle.
//  - STREAM: en=1 for exactly STREAM_CYCLES consecutive cycles (down-counter), then DONE.
//  - DONE:
//    - done=1 for one cycle, then IDLE.
//    - A start in this cycle is ignored; the earliest accepted start is the following cycle.
//  - in_data arriving outside LOAD is not consumed (in_ready=0); the producer holds it.
//  - Widths:
//    - Row counter is $clog2(DIM) bits; it does not wrap within one load.
//    - Stream counter is $clog2(STREAM_CYCLES+1) bits.
//  - Elements pass through bit-exact; no sign extension or saturation.
// CONFIGURATION
//  A_LOADER_TRANSPOSE_EN
//  - Defined:
//    - LOAD captures rows into an internal DIM x DIM buffer and issues no WrEn.
//    - XPOSE then writes DIM rows on consecutive cycles: Arow=r, Ain[i]=buf[i][r] (column r).
//    - STREAM begins after the last XPOSE write.
//  - Undefined:
//    - No buffer and no XPOSE state.
//    - Rows are written as received.
// STRUCTURE
//  - a_loader_pkg: state_t enum (IDLE, LOAD, XPOSE, STREAM, DONE) and an unpack function (packed row -> array).
//  - Sub-module a_loader_xpose_buf: DIM x DIM register buffer, row write / column read.
//    - Instantiated only under A_LOADER_TRANSPOSE_EN.
// TESTING
//  1 DIM=8, start, 8 rows back-to-back with row r elem i = r*8+i
//    -> WrEn high 8 consecutive cycles, Arow 0..7, Ain[i]=r*8+i;
//    -> then en high 15 cycles, done pulses once, busy falls with return to IDLE.
//  2 in_valid toggled 1/0 during LOAD -> WrEn only on handshake cycles; Arow still 0..7 in order; no en before the last WrEn.
//  3 rst=1 asserted on the 4th STREAM cycle -> en=0 the next cycle, no done; a new start after reset loads normally.
//  4 start pulsed during LOAD and STREAM -> ignored; exactly one done; in_valid in IDLE -> in_ready stays 0.
//  5 Elements 8'h80 and 8'h7F -> Ain equals -128 and 127 exactly.
//  6 A_LOADER_TRANSPOSE_EN defined, same input as test 1
//    -> no WrEn during LOAD;
//    -> XPOSE writes Arow=r with Ain[i]=i*8+r;
//    -> then en for 15 cycles.

Source files
------------

// File: rtl/a_loader_pkg.sv
// a_loader_pkg: shared types and helpers for the A-operand loader.
//   state_t    : loader FSM states (XPOSE used only with the transpose build)
//   row_t      : one unpacked A row, DIM signed elements
//   unpack_row : packed stream row -> row_t, element i = data[i*BITS +: BITS]
// The row geometry below sets the default BITS_AB / DIM of a_loader. The
// unpack helper is sized by these constants, so override them here rather
// than on the instance.
package a_loader_pkg;

  localparam int A_BITS_AB = 8;
  localparam int A_DIM     = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    XPOSE,
    STREAM,
    DONE
  } state_t;

  typedef logic signed [A_BITS_AB-1:0] elem_t;
  typedef elem_t [A_DIM-1:0]           row_t;

  function automatic row_t unpack_row(input logic [A_DIM*A_BITS_AB-1:0] data);
    row_t r;
    for (int i = 0; i < A_DIM; i++) r[i] = data[i*A_BITS_AB +: A_BITS_AB];
    return r;
  endfunction

endpackage

// File: rtl/a_loader_xpose_buf.sv
// a_loader_xpose_buf: DIM x DIM register buffer, whole-row write, column read.
//   clk      in   clock
//   wr_en    in   write row wr_row with wr_data
//   wr_row   in   row index for the write
//   wr_data  in   DIM elements of the row
//   rd_col   in   column index for the read
//   rd_data  out  rd_data[i] = buf[i][rd_col] (combinational)
// No reset: contents are always fully rewritten by a load before being read.
module a_loader_xpose_buf #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DIM)-1:0]     wr_row,
  input  logic signed [BITS_AB-1:0]  wr_data [DIM-1:0],
  input  logic [$clog2(DIM)-1:0]     rd_col,
  output logic signed [BITS_AB-1:0]  rd_data [DIM-1:0]
);

  logic signed [BITS_AB-1:0] mem [DIM-1:0][DIM-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_row] <= wr_data;
  end

  always_comb begin
    for (int i = 0; i < DIM; i++) rd_data[i] = mem[i][rd_col];
  end

endmodule

// File: rtl/a_loader.sv
// a_loader: feeds DIM rows of a signed DIM x DIM matrix into A memory, then
// holds the A-memory shift enable for STREAM_CYCLES cycles and pulses done.
//   clk, rst   clock; synchronous active-high reset
//   start      begin a load (honoured only in IDLE)
//   in_valid / in_ready / in_data   packed-row input stream
//   Ain, Arow, WrEn                 A-memory row write port
//   en         A-memory shift enable
//   busy       high outside IDLE
//   done       one-cycle pulse at the end of STREAM
// Build option: define A_LOADER_TRANSPOSE_EN to buffer the matrix during LOAD
// and write its columns as rows in an extra XPOSE state.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting rows (direct build: writing them as they arrive)
// XPOSE  | writing buffered columns as rows (transpose build only)
// STREAM | en high, stream down-counter running
// DONE   | done pulse, back to IDLE
module a_loader
  import a_loader_pkg::*;
#(
  parameter int BITS_AB       = A_BITS_AB,
  parameter int DIM           = A_DIM,
  parameter int STREAM_CYCLES = 2*DIM-1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIM*BITS_AB-1:0]    in_data,
  output logic signed [BITS_AB-1:0] Ain [DIM-1:0],
  output logic [$clog2(DIM)-1:0]    Arow,
  output logic                      WrEn,
  output logic                      en,
  output logic                      busy,
  output logic                      done
);

  localparam int RW = $clog2(DIM);
  localparam int SW = $clog2(STREAM_CYCLES+1);
  localparam logic [RW-1:0] LAST_ROW = RW'(DIM-1);
  localparam logic [SW-1:0] SC_LOAD  = SW'(STREAM_CYCLES);

  state_t        state, state_nx;
  logic [RW-1:0] row_cnt;
  logic [SW-1:0] strm_cnt;
  // Final row write of this load is on the A port this cycle; STREAM follows.
  logic          last_wr;
  logic          hs;
  row_t          in_row;

  assign in_row = unpack_row(in_data);
  assign hs     = in_valid && in_ready;

`ifdef A_LOADER_TRANSPOSE_EN
  logic signed [BITS_AB-1:0] row_arr [DIM-1:0];
  logic signed [BITS_AB-1:0] col     [DIM-1:0];

  always_comb begin
    for (int i = 0; i < DIM; i++) row_arr[i] = in_row[i];
  end

  a_loader_xpose_buf #(.BITS_AB(BITS_AB), .DIM(DIM)) u_buf (
    .clk     (clk),
    .wr_en   (state == LOAD && hs),
    .wr_row  (row_cnt),
    .wr_data (row_arr),
    .rd_col  (row_cnt),
    .rd_data (col)
  );
`endif

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    en       = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: begin
        in_ready = !last_wr;
`ifdef A_LOADER_TRANSPOSE_EN
        if (hs && row_cnt == LAST_ROW) state_nx = XPOSE;
`else
        if (last_wr) state_nx = STREAM;
`endif
      end
`ifdef A_LOADER_TRANSPOSE_EN
      XPOSE: if (last_wr) state_nx = STREAM;
`endif
      STREAM: begin
        en = 1'b1;
        if (strm_cnt == SW'(1)) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row_cnt  <= '0;
      strm_cnt <= '0;
      last_wr  <= 1'b0;
      WrEn     <= 1'b0;
      Arow     <= '0;
      for (int i = 0; i < DIM; i++) Ain[i] <= '0;
    end else begin
      state <= state_nx;
      WrEn  <= 1'b0;
      if (state_nx == STREAM && state != STREAM) strm_cnt <= SC_LOAD;
      else if (state == STREAM)                  strm_cnt <= strm_cnt - 1'b1;
      case (state)
        IDLE: begin
          row_cnt <= '0;
          last_wr <= 1'b0;
        end
        LOAD: if (hs) begin
`ifdef A_LOADER_TRANSPOSE_EN
          // Counter is reused as the column index for XPOSE.
          row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
`else
          WrEn <= 1'b1;
          Arow <= row_cnt;
          for (int i = 0; i < DIM; i++) Ain[i] <= in_row[i];
          if (row_cnt == LAST_ROW) last_wr <= 1'b1;
          else                     row_cnt <= row_cnt + 1'b1;
`endif
        end
`ifdef A_LOADER_TRANSPOSE_EN
        XPOSE: if (!last_wr) begin
          WrEn <= 1'b1;
          Arow <= row_cnt;
          for (int i = 0; i < DIM; i++) Ain[i] <= col[i];
          if (row_cnt == LAST_ROW) last_wr <= 1'b1;
          else                     row_cnt <= row_cnt + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
